data_memory_ext: RTL and testbench

Parametrised successor to the processor's data memory. Adds a valid/ready request interface, per-lane write strobes, configurable read latency and an address-range error flag. After reset, a hardware sweep clears the whole array to zero, so reads never return X. Sits between the load/store unit and the data RAM array; the sweep state machine gates request acceptance.

---
 rtl/data_memory_pkg.sv | 39 +++
 rtl/data_memory_read_pipe.sv | 62 ++++++
 rtl/data_memory_ext.sv | 121 ++++++++++++
 tb/tb_data_memory_ext.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the extended data memory.
// Latency: n/a (types, constants and a combinational merge function only).
// Backpressure: n/a.
package data_memory_pkg;

  // Sweep/run control states
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Upper bounds for the generic lane merge; the top checks its widths against these
  localparam int MAX_DATA_W = 256;
  localparam int MAX_LANES  = 256;

  function automatic int calc_num_lanes(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

  // Replace each strobed lane of old_dat with the matching lane of new_dat
  function automatic logic [MAX_DATA_W-1:0] lane_merge(
    input logic [MAX_DATA_W-1:0] old_dat,
    input logic [MAX_DATA_W-1:0] new_dat,
    input logic [MAX_LANES-1:0]  strb,
    input int                    lane_w
  );
    logic [MAX_DATA_W-1:0] res;
    logic [7:0]            bit_idx;
    logic [7:0]            lane_idx;
    res = old_dat;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      bit_idx  = 8'(i);
      lane_idx = 8'(i / lane_w);
      if (strb[lane_idx]) res[bit_idx] = new_dat[bit_idx];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_memory_read_pipe.sv
// Read response pipeline: valid/data/err register chain, 1 or 2 stages deep.
// Latency: LATENCY cycles from i_vld to o_vld; o_dat holds between responses.
// Backpressure: none; one entry may enter every cycle and the consumer must always accept.
module data_memory_read_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_vld,
  input  logic [DATA_WIDTH-1:0] i_dat,
  input  logic                  i_err,
  output logic                  o_vld,
  output logic [DATA_WIDTH-1:0] o_dat,
  output logic                  o_err
);

  logic                  r_vld1;
  logic [DATA_WIDTH-1:0] r_dat1;
  logic                  r_err1;

  // First stage: capture the read result; data only moves with a valid entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld1 <= 1'b0;
      r_dat1 <= '0;
      r_err1 <= 1'b0;
    end else begin
      r_vld1 <= i_vld;
      r_err1 <= i_vld & i_err;
      if (i_vld) r_dat1 <= i_dat;
    end
  end

  if (LATENCY == 2) begin : g_lat2
    logic                  r_vld2;
    logic [DATA_WIDTH-1:0] r_dat2;
    logic                  r_err2;

    // Second stage: extra output register, same hold rules as the first
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld2 <= 1'b0;
        r_dat2 <= '0;
        r_err2 <= 1'b0;
      end else begin
        r_vld2 <= r_vld1;
        r_err2 <= r_err1;
        if (r_vld1) r_dat2 <= r_dat1;
      end
    end

    assign o_vld = r_vld2;
    assign o_dat = r_dat2;
    assign o_err = r_err2;
  end else begin : g_lat1
    assign o_vld = r_vld1;
    assign o_dat = r_dat1;
    assign o_err = r_err1;
  end

endmodule

// File: rtl/data_memory_ext.sv
// Word-addressed data RAM with lane strobes, range-error flag and a post-reset clear sweep.
// Latency: reads respond READ_LATENCY cycles after acceptance; writes are posted.
// Backpressure: req_ready low during the clear sweep, then always high; responses cannot be stalled.
module data_memory_ext
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 256,
  parameter int LANE_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  localparam int NUM_LANES   = calc_num_lanes(DATA_WIDTH, LANE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_LANES-1:0]  req_wstrb,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if ((DATA_WIDTH % LANE_WIDTH) != 0) begin : g_chk_lane
    $fatal(1, "data_memory_ext: DATA_WIDTH must be a multiple of LANE_WIDTH");
  end
  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_chk_lat
    $fatal(1, "data_memory_ext: READ_LATENCY must be 1 or 2");
  end
  if ((DEPTH < 1) || (DEPTH > (2 ** ADDR_WIDTH))) begin : g_chk_depth
    $fatal(1, "data_memory_ext: DEPTH must be in 1..2**ADDR_WIDTH");
  end
  if ((DATA_WIDTH > MAX_DATA_W) || (NUM_LANES > MAX_LANES)) begin : g_chk_max
    $fatal(1, "data_memory_ext: DATA_WIDTH or lane count exceeds package limits");
  end

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clear_ptr;
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  logic                  w_accept;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_in_range;
  logic                  w_sweep_last;
  logic [IDX_W-1:0]      w_req_idx;
  logic [IDX_W-1:0]      w_clr_idx;
  logic [DATA_WIDTH-1:0] w_rd_raw;
  logic [DATA_WIDTH-1:0] w_rd_dat;
  logic [DATA_WIDTH-1:0] w_wr_merged;

  assign w_accept     = req_valid & req_ready;
  assign w_wr_acc     = w_accept & req_write;
  assign w_rd_acc     = w_accept & ~req_write;
  assign w_in_range   = ({1'b0, req_addr} < (ADDR_WIDTH + 1)'(DEPTH));
  assign w_sweep_last = (r_clear_ptr == ADDR_WIDTH'(DEPTH - 1));
  assign w_req_idx    = req_addr[IDX_W-1:0];
  assign w_clr_idx    = r_clear_ptr[IDX_W-1:0];

  // Out-of-range reads return zero; the raw array value is only meaningful in range
  assign w_rd_raw    = r_mem[w_req_idx];
  assign w_rd_dat    = w_in_range ? w_rd_raw : '0;
  assign w_wr_merged = DATA_WIDTH'(lane_merge(MAX_DATA_W'(w_rd_raw), MAX_DATA_W'(req_wdata),
                                              MAX_LANES'(req_wstrb), LANE_WIDTH));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_INIT;
    else     r_state <= w_state_nxt;
  end

  // Next state: leave the sweep once the last word has been cleared
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (w_sweep_last) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Outputs: requests are only taken once the array is fully cleared
  always_comb begin
    init_busy = (r_state == ST_INIT);
    req_ready = (r_state == ST_RUN);
  end

  // Sweep pointer restarts from zero on every reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_clear_ptr <= '0;
    else if (r_state == ST_INIT) r_clear_ptr <= r_clear_ptr + 1'b1;
  end

  // Array update: sweep clears one word per cycle, otherwise in-range strobed writes
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT)         r_mem[w_clr_idx] <= '0;
    else if (w_wr_acc && w_in_range) r_mem[w_req_idx] <= w_wr_merged;
  end

  data_memory_read_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_read_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_vld (w_rd_acc),
    .i_dat (w_rd_dat),
    .i_err (~w_in_range),
    .o_vld (rsp_valid),
    .o_dat (rsp_rdata),
    .o_err (rsp_err)
  );

endmodule

// File: tb/tb_data_memory_ext.sv
// Randomised scoreboard bench for data_memory_ext (32-bit words, byte lanes, 200 words, 2-cycle reads).
// Latency: response timing is checked against the accept cycle of each read.
// Backpressure: requests are only driven while the block is out of its clear sweep.
module tb_data_memory_ext;

  localparam int DW    = 32;
  localparam int LW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 200;
  localparam int RL    = 2;
  localparam int NL    = DW / LW;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [NL-1:0] req_wstrb = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          init_busy;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] last_rdata = '0;
  logic [31:0] ref_mem [0:DEPTH-1];

  data_memory_ext #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .DEPTH        (DEPTH),
    .LANE_WIDTH   (LW),
    .READ_LATENCY (RL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per response and watches idle-cycle behaviour
  always @(negedge clk) begin
    if (rst) begin
      chk("rsp_valid_in_reset", {31'b0, rsp_valid}, 32'd0);
      last_rdata = '0;
    end else if (rsp_valid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 data %h want no response", rsp_rdata);
      end else begin
        mon_e = sbq.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.dat);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
        chk("rsp_latency", 32'(cyc), 32'(mon_e.cyc + RL));
      end
      last_rdata = rsp_rdata;
    end else begin
      chk("rdata_hold", rsp_rdata, last_rdata);
      chk("err_idle", {31'b0, rsp_err}, 32'd0);
    end
  end

  // Issue one request this cycle and record its architectural effect in the model
  task automatic req(input bit wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    if (wr) begin
      if (int'(a) < DEPTH)
        for (int l = 0; l < NL; l++)
          if (s[l]) ref_mem[a][l*LW +: LW] = d[l*LW +: LW];
    end else begin
      e.err = (int'(a) >= DEPTH);
      e.dat = (int'(a) < DEPTH) ? ref_mem[a] : 32'd0;
      e.cyc = cyc;
      sbq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
  endtask

  // Count posedges after reset release until the block accepts requests (bounded)
  task automatic wait_sweep(input string nm);
    int n;
    n = 0;
    while (n < DEPTH + 20) begin
      @(posedge clk);
      n++;
      #1;
      if (req_ready) break;
    end
    chk(nm, 32'(n), 32'(DEPTH));
    chk({nm, "_busy_low"}, {31'b0, init_busy}, 32'd0);
    clear_model();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_model();
    repeat (2) @(negedge clk);
    chk("rst_init_busy", {31'b0, init_busy}, 32'd1);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);

    // Reset in the middle of the sweep must restart it from zero
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midinit_busy", {31'b0, init_busy}, 32'd1);
    rst = 1'b0;
    chk("release_busy", {31'b0, init_busy}, 32'd1);
    wait_sweep("sweep_cycles");

    // Every word reads back as zero after the sweep
    for (int a = 0; a < DEPTH; a++) req(1'b0, 8'(a), 32'd0, 4'h0);

    // Write then read next cycle
    req(1'b1, 8'd3, 32'h000000A5, 4'hF);
    req(1'b0, 8'd3, 32'd0, 4'h0);

    // Partial lane writes
    req(1'b1, 8'd7, 32'h11223344, 4'hF);
    req(1'b1, 8'd7, 32'hAABBCCDD, 4'h5);
    req(1'b0, 8'd7, 32'd0, 4'h0);
    idle(1);
    chk("strobe_model", ref_mem[7], 32'h11BB33DD);

    // Back-to-back reads at full throughput
    req(1'b1, 8'd0, 32'd10, 4'hF);
    req(1'b1, 8'd1, 32'd20, 4'hF);
    req(1'b1, 8'd2, 32'd30, 4'hF);
    req(1'b1, 8'd3, 32'd40, 4'hF);
    idle(2);
    for (int a = 0; a < 4; a++) req(1'b0, 8'(a), 32'd0, 4'h0);
    idle(1);

    // Out-of-range write is dropped, read flags an error
    req(1'b1, 8'd199, 32'h0000BEEF, 4'hF);
    req(1'b1, 8'd250, 32'h00000055, 4'hF);
    req(1'b0, 8'd250, 32'd0, 4'h0);
    req(1'b0, 8'd199, 32'd0, 4'h0);
    req(1'b1, 8'd0, 32'h12345678, 4'h0);
    req(1'b0, 8'd0, 32'd0, 4'h0);
    req(1'b0, 8'd255, 32'd0, 4'h0);

    // Random traffic with gaps, mixed strobes and occasional out-of-range addresses
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else if ($urandom_range(0, 1) == 0)
        req(1'b1, 8'($urandom_range(0, 255)), $urandom, 4'($urandom_range(0, 15)));
      else
        req(1'b0, 8'($urandom_range(0, 255)), 32'd0, 4'h0);
    end
    idle(RL + 3);
    chk("sb_drained_mid", 32'(sbq.size()), 32'd0);

    // Reset with a read in flight: no response, array cleared again
    req(1'b1, 8'd5, 32'hDEADBEEF, 4'hF);
    req(1'b0, 8'd5, 32'd0, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    sbq.delete();
    #1;
    chk("midrun_init_busy", {31'b0, init_busy}, 32'd1);
    chk("midrun_req_ready", {31'b0, req_ready}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_sweep("resweep_cycles");
    req(1'b0, 8'd5, 32'd0, 4'h0);
    req(1'b0, 8'd199, 32'd0, 4'h0);
    req(1'b0, 8'd7, 32'd0, 4'h0);
    idle(RL + 3);
    chk("sb_drained_end", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
